// File: rtl/cpu_mux_pkg.sv
// Shared constants and helpers for the CPU operand/writeback bus multiplexers.
package cpu_mux_pkg;

    localparam int   CPU_WORD_W = 6;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Bit offset of channel k inside a packed {ch[N-1], ..., ch[0]} bus.
    function automatic int unsigned slice_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin picker: first set request after 'last', wrapping modulo CHANNELS.
module rr_priority_pick #(
    parameter int CHANNELS = 8,
    parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    last,
    output logic [SEL_W-1:0]    grant,
    output logic                grant_valid
);

    localparam int unsigned CH_U = CHANNELS;

    logic [CHANNELS-1:0] rot;
    int unsigned         off;

    // base + 1 + off never reaches 2*CHANNELS, so one subtraction wraps it.
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                   input int unsigned off_in);
        int unsigned s;
        s = 32'(base) + 32'd1 + off_in;
        if (s >= CH_U) s = s - CH_U;
        return SEL_W'(s);
    endfunction

    always_comb begin
        rot = '0;
        for (int unsigned i = 0; i < CH_U; i++) begin
            rot[i] = req[wrap_add(last, i)];
        end
    end

    always_comb begin
        off         = 0;
        grant_valid = 1'b0;
        for (int unsigned i = 0; i < CH_U; i++) begin
            if (rot[i] && !grant_valid) begin
                grant_valid = 1'b1;
                off         = i;
            end
        end
        grant = wrap_add(last, off);
    end

endmodule

// File: rtl/bus_mux_arb.sv
// N-channel W-bit bus multiplexer with fixed-select or round-robin grant,
// valid/ready handshakes and a single registered output stage.
module bus_mux_arb
    import cpu_mux_pkg::*;
#(
    parameter int WIDTH    = CPU_WORD_W,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam logic [SEL_W:0]   CH_L      = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_INIT = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0] chan_data [CHANNELS];
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_valid;
    logic             fixed_ok;
    logic [SEL_W-1:0] grant;
    logic             granted;
    logic             load_en;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        localparam int unsigned LSB = slice_lsb(k, WIDTH);
        assign chan_data[k] = in_data[LSB +: WIDTH];
    end

    rr_priority_pick #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_pick (
        .req         (in_valid),
        .last        (last),
        .grant       (rr_grant),
        .grant_valid (rr_valid)
    );

    assign load_en = !out_valid || out_ready;

    always_comb begin
        fixed_ok = 1'b0;
        if ({1'b0, sel} < CH_L) fixed_ok = in_valid[sel];
    end

    always_comb begin
        grant   = sel;
        granted = fixed_ok;
        if (mode == MODE_RR) begin
            grant   = rr_grant;
            granted = rr_valid;
        end
    end

    // A granted index is always in range, so the one-hot write cannot overflow.
    always_comb begin
        in_ready = '0;
        if (!rst && load_en && granted) in_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            last      <= LAST_INIT;
        end else if (load_en) begin
            if (granted) begin
                out_data  <= chan_data[grant];
                out_chan  <= grant;
                out_valid <= 1'b1;
                last      <= grant;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_mux_arb.sv
// Directed bench for bus_mux_arb: an 8-channel and a 6-channel instance.
module tb_bus_mux_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8-channel instance
    logic        mode8;
    logic [2:0]  sel8;
    logic [47:0] data8;
    logic [7:0]  valid8;
    logic [7:0]  ready8;
    logic [5:0]  odata8;
    logic [2:0]  ochan8;
    logic        ovalid8;
    logic        oready8;

    // 6-channel instance
    logic        mode6;
    logic [2:0]  sel6;
    logic [35:0] data6;
    logic [5:0]  valid6;
    logic [5:0]  ready6;
    logic [5:0]  odata6;
    logic [2:0]  ochan6;
    logic        ovalid6;
    logic        oready6;

    int vectors    = 0;
    int miscompares = 0;

    logic [5:0] d8 [8] = '{6'h01, 6'h12, 6'h23, 6'h11, 6'h05, 6'h2A, 6'h16, 6'h37};
    int rr_seq [6] = '{0, 2, 5, 7, 0, 2};
    int rr6_seq [7] = '{3, 4, 5, 0, 1, 2, 3};

    bus_mux_arb #(.WIDTH(6), .CHANNELS(8)) u8 (
        .clk(clk), .rst(rst), .mode(mode8), .sel(sel8), .in_data(data8),
        .in_valid(valid8), .in_ready(ready8), .out_data(odata8),
        .out_chan(ochan8), .out_valid(ovalid8), .out_ready(oready8)
    );

    bus_mux_arb #(.WIDTH(6), .CHANNELS(6)) u6 (
        .clk(clk), .rst(rst), .mode(mode6), .sel(sel6), .in_data(data6),
        .in_valid(valid6), .in_ready(ready6), .out_data(odata6),
        .out_chan(ochan6), .out_valid(ovalid6), .out_ready(oready6)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) data8[k*6 +: 6] = d8[k];
        for (int k = 0; k < 6; k++) data6[k*6 +: 6] = 6'(6'h20 + k);
        mode6 = 1'b0; sel6 = 3'd0; valid6 = '0; oready6 = 1'b1;

        // Reset with every channel requesting
        rst = 1'b1; mode8 = 1'b1; sel8 = 3'd0; valid8 = 8'hFF; oready8 = 1'b1;
        tick(); tick();
        chk("rst_out_valid", 64'(ovalid8), 64'd0);
        chk("rst_out_data", 64'(odata8), 64'd0);
        chk("rst_in_ready", 64'(ready8), 64'd0);
        rst = 1'b0; #1;
        chk("rr_first_ready", 64'(ready8), 64'h01);
        tick();
        chk("rr_first_chan", 64'(ochan8), 64'd0);
        chk("rr_first_valid", 64'(ovalid8), 64'd1);
        chk("rr_first_data", 64'(odata8), 64'h01);
        chk("rr_second_ready", 64'(ready8), 64'h02);

        // Fixed select
        mode8 = 1'b0; sel8 = 3'd5; valid8 = 8'h20; #1;
        chk("fix_ready", 64'(ready8), 64'h20);
        tick();
        chk("fix_data", 64'(odata8), 64'h2A);
        chk("fix_chan", 64'(ochan8), 64'd5);
        chk("fix_valid", 64'(ovalid8), 64'd1);
        sel8 = 3'd3; #1;
        chk("fix_nogrant_ready", 64'(ready8), 64'h00);
        tick();
        chk("fix_drain_valid", 64'(ovalid8), 64'd0);
        chk("fix_hold_data", 64'(odata8), 64'h2A);
        chk("fix_hold_chan", 64'(ochan8), 64'd5);

        // Round-robin fairness from a fresh pointer
        rst = 1'b1; tick();
        rst = 1'b0; mode8 = 1'b1; valid8 = 8'hA5;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_seq_chan", 64'(ochan8), 64'(rr_seq[i]));
            chk("rr_seq_data", 64'(odata8), 64'(d8[rr_seq[i]]));
            chk("rr_seq_valid", 64'(ovalid8), 64'd1);
        end

        // Backpressure holds the registered word
        valid8 = 8'h08; tick();
        chk("bp_load_data", 64'(odata8), 64'h11);
        chk("bp_load_chan", 64'(ochan8), 64'd3);
        oready8 = 1'b0; valid8 = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 64'(ready8), 64'h00);
            tick();
            chk("bp_hold_data", 64'(odata8), 64'h11);
            chk("bp_hold_valid", 64'(ovalid8), 64'd1);
        end
        oready8 = 1'b1; #1;
        chk("bp_release_ready", 64'(ready8), 64'h10);
        tick();
        chk("bp_next_chan", 64'(ochan8), 64'd4);
        chk("bp_next_data", 64'(odata8), 64'h05);

        // Reset while a word is stalled
        oready8 = 1'b0; tick();
        chk("mid_stall_valid", 64'(ovalid8), 64'd1);
        rst = 1'b1; #1;
        chk("mid_rst_ready", 64'(ready8), 64'h00);
        tick();
        chk("mid_rst_valid", 64'(ovalid8), 64'd0);
        chk("mid_rst_data", 64'(odata8), 64'd0);
        chk("mid_rst_chan", 64'(ochan8), 64'd0);
        rst = 1'b0; oready8 = 1'b1; #1;
        chk("mid_restart_ready", 64'(ready8), 64'h01);
        tick();
        chk("mid_restart_chan", 64'(ochan8), 64'd0);

        // Six channels: out-of-range sel, then round-robin wraps at 5
        mode6 = 1'b0; sel6 = 3'd2; valid6 = 6'h3F; #1;
        chk("np2_fix_ready", 64'(ready6), 64'h04);
        tick();
        chk("np2_fix_chan", 64'(ochan6), 64'd2);
        chk("np2_fix_data", 64'(odata6), 64'h22);
        sel6 = 3'd7; #1;
        chk("np2_oor_ready", 64'(ready6), 64'h00);
        tick();
        chk("np2_oor_valid", 64'(ovalid6), 64'd0);
        chk("np2_oor_chan", 64'(ochan6), 64'd2);
        mode6 = 1'b1; #1;
        chk("np2_rr_ready", 64'(ready6), 64'h08);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("np2_rr_chan", 64'(ochan6), 64'(rr6_seq[i]));
            chk("np2_rr_data", 64'(odata6), 64'(6'h20 + rr6_seq[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
